// File: rtl/f_run_monitor_pkg.sv
// ---------------------------------------------------------------------------
// f_mon_pkg
//   Shared definitions for the F run monitor:
//   - run_state_e : run-detection FSM states (LOW, RUN, HIT)
//   - DEF_CNT_W   : default counter / snapshot width
//   - DEF_RUN_LEN : default number of consecutive highs that qualify a run
//   - sat_inc()   : saturating increment against a caller-supplied ceiling
// ---------------------------------------------------------------------------
package f_mon_pkg;

    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned DEF_RUN_LEN = 3;

    typedef enum logic [1:0] {
        LOW = 2'd0,
        RUN = 2'd1,
        HIT = 2'd2
    } run_state_e;

    // Increment v by one unless it has already reached max.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/f_run_monitor_if.sv
// ---------------------------------------------------------------------------
// f_run_monitor_if
//   Bundles the F sample input, control inputs and the snapshot handshake of
//   f_run_monitor.
//   master : drives F, clear, snap_req, snap_ack; observes the outputs
//   slave  : the monitor itself
//   Signals: F, clear, snap_req, snap_ack, rise, run_det, snap_valid,
//            snap_edges[CNT_W], snap_runs[CNT_W]
// ---------------------------------------------------------------------------
interface f_run_monitor_if
    import f_mon_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) ();

    logic             F;
    logic             clear;
    logic             snap_req;
    logic             snap_ack;
    logic             rise;
    logic             run_det;
    logic             snap_valid;
    logic [CNT_W-1:0] snap_edges;
    logic [CNT_W-1:0] snap_runs;

    modport master (
        output F, clear, snap_req, snap_ack,
        input  rise, run_det, snap_valid, snap_edges, snap_runs
    );

    modport slave (
        input  F, clear, snap_req, snap_ack,
        output rise, run_det, snap_valid, snap_edges, snap_runs
    );

endinterface

// File: rtl/f_run_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// f_sat_counter
//   Saturating up-counter with synchronous clear (clear beats increment).
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   inc   : count up by one this cycle (held at all-ones)
//   clr   : synchronous clear to zero
//   q     : current count
// ---------------------------------------------------------------------------
module f_sat_counter
    import f_mon_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = CNT_W'(sat_inc(32'(q_q), 32'(CntMax)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/f_run_monitor.sv
// ---------------------------------------------------------------------------
// f_run_monitor
//   Registered consumer of the combinational F output. Flags each rising edge
//   of F, detects runs of at least RUN_LEN consecutive high samples, counts
//   edges and qualified runs in saturating counters and exports both counts
//   through a req/ack snapshot handshake.
//   Clock   : clock, all state updates on posedge
//   reset_b : asynchronous active-low reset
//   bus     : f_run_monitor_if.slave
//             in  F, clear, snap_req, snap_ack
//             out rise, run_det, snap_valid, snap_edges, snap_runs
// ---------------------------------------------------------------------------
module f_run_monitor
    import f_mon_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned RUN_LEN = DEF_RUN_LEN
) (
    input  logic           Clock,
    input  logic           reset_b,
    f_run_monitor_if.slave bus
);

    localparam int unsigned     LenW     = $clog2(RUN_LEN + 1);
    localparam logic [LenW-1:0] RunLenL  = LenW'(RUN_LEN);
    localparam logic [LenW-1:0] RunLenM1 = LenW'(RUN_LEN - 1);

    // Sample stage
    logic f_q;
    logic rise_q;
    logic edge_inc;

    // Run FSM
    run_state_e      state_q;
    logic [LenW-1:0] run_len_q;
    logic            run_det_q;
    logic            run_inc;

    // Counters and snapshot
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic             snap_valid_q;
    logic [CNT_W-1:0] snap_edges_q;
    logic [CNT_W-1:0] snap_runs_q;

    // clear deliberately leaves the sample stage alone so a clear while F is
    // high never produces a spurious edge afterwards.
    assign edge_inc = bus.F & ~f_q;

    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            f_q    <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            f_q    <= bus.F;
            rise_q <= edge_inc;
        end
    end

    // The RUN_LEN-th consecutive high is the one that moves RUN into HIT;
    // that transition alone counts the run.
    assign run_inc = (state_q == RUN) && bus.F && (run_len_q == RunLenM1);

    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= LOW;
            run_len_q <= '0;
            run_det_q <= 1'b0;
        end else if (bus.clear) begin
            state_q   <= LOW;
            run_len_q <= '0;
            run_det_q <= 1'b0;
        end else begin
            unique case (state_q)
                LOW: begin
                    if (bus.F) begin
                        state_q   <= RUN;
                        run_len_q <= LenW'(1);
                    end
                end
                RUN: begin
                    if (!bus.F) begin
                        state_q   <= LOW;
                        run_len_q <= '0;
                    end else if (run_len_q == RunLenM1) begin
                        state_q   <= HIT;
                        run_len_q <= RunLenL;
                        run_det_q <= 1'b1;
                    end else begin
                        run_len_q <= run_len_q + 1'b1;
                    end
                end
                HIT: begin
                    // run_len stays parked at RUN_LEN however long F stays high
                    if (!bus.F) begin
                        state_q   <= LOW;
                        run_len_q <= '0;
                        run_det_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= LOW;
                    run_len_q <= '0;
                    run_det_q <= 1'b0;
                end
            endcase
        end
    end

    f_sat_counter #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clk   (Clock),
        .rst_n (reset_b),
        .inc   (edge_inc),
        .clr   (bus.clear),
        .q     (edge_cnt)
    );

    f_sat_counter #(
        .CNT_W (CNT_W)
    ) u_run_cnt (
        .clk   (Clock),
        .rst_n (reset_b),
        .inc   (run_inc),
        .clr   (bus.clear),
        .q     (run_cnt)
    );

    // Capture takes the counter values before this edge's update. A request
    // arriving while a snapshot is pending is dropped, including one that
    // coincides with the ack. clear never touches the snapshot.
    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            snap_valid_q <= 1'b0;
            snap_edges_q <= '0;
            snap_runs_q  <= '0;
        end else if (!snap_valid_q) begin
            if (bus.snap_req) begin
                snap_valid_q <= 1'b1;
                snap_edges_q <= edge_cnt;
                snap_runs_q  <= run_cnt;
            end
        end else if (bus.snap_ack) begin
            snap_valid_q <= 1'b0;
        end
    end

    assign bus.rise       = rise_q;
    assign bus.run_det    = run_det_q;
    assign bus.snap_valid = snap_valid_q;
    assign bus.snap_edges = snap_edges_q;
    assign bus.snap_runs  = snap_runs_q;

endmodule

// File: tb/tb_f_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_f_run_monitor
//   Directed bench for f_run_monitor. Main instance uses CNT_W=8, RUN_LEN=3;
//   a second instance with CNT_W=2 exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_f_run_monitor;

    logic Clock;
    logic reset_b;

    int total;
    int bad;

    f_run_monitor_if #(.CNT_W(8)) bus ();
    f_run_monitor_if #(.CNT_W(2)) bus2 ();

    f_run_monitor #(
        .CNT_W   (8),
        .RUN_LEN (3)
    ) u_dut (
        .Clock   (Clock),
        .reset_b (reset_b),
        .bus     (bus)
    );

    f_run_monitor #(
        .CNT_W   (2),
        .RUN_LEN (3)
    ) u_dut_sat (
        .Clock   (Clock),
        .reset_b (reset_b),
        .bus     (bus2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one active edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic snap_and_check(input string tag, input logic [7:0] e, input logic [7:0] r);
        bus.snap_req = 1'b1;
        step();
        bus.snap_req = 1'b0;
        check_eq({tag, "_valid"}, 32'(bus.snap_valid), 32'd1);
        check_eq({tag, "_edges"}, 32'(bus.snap_edges), 32'(e));
        check_eq({tag, "_runs"}, 32'(bus.snap_runs), 32'(r));
    endtask

    task automatic ack();
        bus.snap_ack = 1'b1;
        step();
        bus.snap_ack = 1'b0;
        check_eq("ack_valid", 32'(bus.snap_valid), 32'd0);
    endtask

    // Per-cycle vectors: F, clear, expected rise, expected run_det.
    logic t1_f   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic t1_r   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic t1_d   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic t2_f   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic t2_r   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic t4_clr [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic t4_f   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic t4_r   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic t4_d   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        total = 0;
        bad   = 0;
        reset_b       = 1'b0;
        bus.F         = 1'b0;
        bus.clear     = 1'b0;
        bus.snap_req  = 1'b0;
        bus.snap_ack  = 1'b0;
        bus2.F        = 1'b0;
        bus2.clear    = 1'b0;
        bus2.snap_req = 1'b0;
        bus2.snap_ack = 1'b0;

        // Reset values, before any clock edge
        #3;
        check_eq("rst_rise", 32'(bus.rise), 32'd0);
        check_eq("rst_run_det", 32'(bus.run_det), 32'd0);
        check_eq("rst_snap_valid", 32'(bus.snap_valid), 32'd0);
        check_eq("rst_snap_edges", 32'(bus.snap_edges), 32'd0);
        check_eq("rst_snap_runs", 32'(bus.snap_runs), 32'd0);
        step();
        step();
        reset_b = 1'b1;

        // Single long run: one edge, one qualified run, run_det for 2 cycles
        for (int i = 0; i < 6; i++) begin
            bus.F = t1_f[i];
            step();
            check_eq($sformatf("t1_rise_%0d", i), 32'(bus.rise), 32'(t1_r[i]));
            check_eq($sformatf("t1_det_%0d", i), 32'(bus.run_det), 32'(t1_d[i]));
        end
        snap_and_check("t1_snap", 8'd1, 8'd1);
        ack();
        check_eq("t1_held_edges", 32'(bus.snap_edges), 32'd1);

        // Short pulses never qualify
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.F = t2_f[i];
            step();
            check_eq($sformatf("t2_rise_%0d", i), 32'(bus.rise), 32'(t2_r[i]));
            check_eq($sformatf("t2_det_%0d", i), 32'(bus.run_det), 32'd0);
        end
        snap_and_check("t2_snap", 8'd3, 8'd0);
        ack();

        // CNT_W=2: five isolated highs saturate at 3
        for (int i = 0; i < 5; i++) begin
            bus2.F = 1'b1;
            step();
            bus2.F = 1'b0;
            step();
        end
        bus2.snap_req = 1'b1;
        step();
        bus2.snap_req = 1'b0;
        check_eq("t3_valid", 32'(bus2.snap_valid), 32'd1);
        check_eq("t3_edges_sat", 32'(bus2.snap_edges), 32'd3);
        check_eq("t3_runs", 32'(bus2.snap_runs), 32'd0);

        // clear on the 2nd high of a 6-high run: FSM restarts, no edge counted
        for (int i = 0; i < 7; i++) begin
            bus.F     = t4_f[i];
            bus.clear = t4_clr[i];
            step();
            check_eq($sformatf("t4_rise_%0d", i), 32'(bus.rise), 32'(t4_r[i]));
            check_eq($sformatf("t4_det_%0d", i), 32'(bus.run_det), 32'(t4_d[i]));
        end
        bus.clear = 1'b0;
        snap_and_check("t4_snap", 8'd0, 8'd1);
        ack();

        // Snapshot frozen while valid; ack+req together drops the req
        snap_and_check("t5_first", 8'd0, 8'd1);
        bus.F = 1'b1;
        step();
        bus.F = 1'b0;
        step();
        bus.snap_req = 1'b1;
        step();
        check_eq("t5_frozen_valid", 32'(bus.snap_valid), 32'd1);
        check_eq("t5_frozen_edges", 32'(bus.snap_edges), 32'd0);
        bus.snap_ack = 1'b1;
        step();
        bus.snap_req = 1'b0;
        bus.snap_ack = 1'b0;
        check_eq("t5_ackreq_valid", 32'(bus.snap_valid), 32'd0);
        check_eq("t5_ackreq_edges", 32'(bus.snap_edges), 32'd0);
        step();
        check_eq("t5_no_recapture", 32'(bus.snap_valid), 32'd0);
        snap_and_check("t5_second", 8'd1, 8'd1);

        // Async reset in HIT with a pending snapshot
        bus.F = 1'b1;
        step();
        step();
        step();
        check_eq("t6_pre_det", 32'(bus.run_det), 32'd1);
        check_eq("t6_pre_valid", 32'(bus.snap_valid), 32'd1);
        reset_b = 1'b0;
        #1;
        check_eq("t6_rst_rise", 32'(bus.rise), 32'd0);
        check_eq("t6_rst_det", 32'(bus.run_det), 32'd0);
        check_eq("t6_rst_valid", 32'(bus.snap_valid), 32'd0);
        check_eq("t6_rst_edges", 32'(bus.snap_edges), 32'd0);
        check_eq("t6_rst_runs", 32'(bus.snap_runs), 32'd0);
        step();
        reset_b = 1'b1;
        // F still high: the first sample after release counts as a rising edge
        step();
        check_eq("t6_post_rise", 32'(bus.rise), 32'd1);
        check_eq("t6_post_det", 32'(bus.run_det), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/f_run_monitor.md
# f_run_monitor

Registered consumer stage for the combinational F output of the schematic 3.25 function block. It samples F every Clock edge and pulses on each rising transition. It counts rising edges and qualified high runs (F high for at least RUN_LEN consecutive samples) in saturating counters. Counter values are exported through a req/ack snapshot handshake, so a testbench or downstream logic can read a coherent pair of values.

## Interface
- CNT_W, 8, width of both counters and snapshot outputs (≥2)
- RUN_LEN, 3, consecutive high samples that qualify a run (2..15)

- Clock  in  1  single clock; all state updates on posedge
- reset_b  in  1  asynchronous, active-low reset
- F  in  1  function output; synchronous to Clock, stable at posedge
- clear  in  1  synchronous clear of counters and run FSM
- snap_req  in  1  one-cycle request to capture counters
- snap_ack  in  1  consumer accepts current snapshot
- rise  out  1  registered pulse, one cycle per 0→1 on F
- run_det  out  1  high while current run length ≥ RUN_LEN
- snap_valid  out  1  snapshot outputs hold valid data
- snap_edges  out  CNT_W  captured rising-edge count
- snap_runs  out  CNT_W  captured qualified-run count

## Operation
- Sample stage: f_q <= F every cycle; rise <= F & ~f_q. clear does not affect f_q or rise, so clearing while F is high never fabricates an edge.
- Edge counter: edge_cnt increments when F & ~f_q, saturating at 2^CNT_W−1.
- Run FSM, evaluated on sampled F:
  - LOW → RUN when F=1; sets run_len=1.
  - RUN: F=1 increments run_len. On reaching RUN_LEN, go to HIT and increment run_cnt (saturating). F=0 returns to LOW.
  - HIT: stays while F=1; F=0 returns to LOW. run_len does not advance further.
  - run_det = (state==HIT), registered.
- One qualified run is counted once, regardless of its length.
- clear forces LOW, run_len=0, edge_cnt=0, run_cnt=0, run_det=0. If clear and an increment occur in the same cycle, clear wins.
  - After clear with F still high, the FSM restarts from LOW on the next sample, so a new run can be counted. edge_cnt is not incremented, because there was no edge.
- Snapshot handshake:
  - When snap_req=1 and snap_valid=0, capture the pre-update edge_cnt/run_cnt into snap_edges/snap_runs and set snap_valid.
  - While snap_valid=1, snap_req is ignored and the snapshot outputs are frozen.
  - snap_ack while valid clears snap_valid next cycle; the data is held.
  - snap_ack with snap_valid=0 is ignored.
  - Simultaneous snap_ack and snap_req while valid: ack is taken and req is dropped.
  - clear does not touch the snapshot.
- Saturation: counters hold at all-ones; no wrap.

## Timing
- Reset (reset_b=0, async): f_q=0, rise=0, run_det=0, state=LOW, run_len=0, edge_cnt=0, run_cnt=0, snap_valid=0, snap_edges=0, snap_runs=0.
- F rising edge sampled at edge k: rise=1 during cycle k→k+1 only; edge_cnt updated at edge k.
- run_det rises at the edge where the RUN_LEN-th consecutive high is sampled, and falls at the edge where F=0 is sampled.
- Snapshot latency: snap_req at edge k → snap_valid=1 after edge k. Snapshot values equal the counter values before edge k.
- Reset asserted mid-run or mid-handshake aborts immediately to reset values. The first sample after release is treated as following F=0.

## Structure
- Shared package f_mon_pkg:
  - state enum {LOW, RUN, HIT}
  - default CNT_W/RUN_LEN constants
  - saturating-increment function
- One natural sub-module, f_sat_counter (CNT_W, inc, clr, q), instantiated for edge_cnt and run_cnt.
- run_len width: $clog2(RUN_LEN+1).

## Test plan
- Reset release with F=0, then F = 0,1,1,1,1,0 → rise pulses once; run_det high for 2 cycles; after snap_req, snapshot shows edges=1, runs=1.
- F = 1,0,1,0,1,1,0 (RUN_LEN=3) → 3 rise pulses, run_det never high; snapshot shows edges=3, runs=0.
- CNT_W=2, 5 isolated one-cycle highs → edge_cnt saturates at 3 with no wrap.
- clear asserted on the 2nd high of a 6-cycle run → counters 0, no rise pulse. FSM restarts, so run_det asserts on the 5th high and runs=1.
- snap_req while snap_valid=1 with counters changing → snapshot unchanged. Then snap_ack together with snap_req → valid drops, no recapture.
- reset_b pulsed low mid-HIT with snap_valid=1 → all outputs 0 immediately, asynchronously (checked before the next Clock edge).
